// File: rtl/cpu_pkg.sv
// Shared widths and encodings for the RAM bank arbiter and its round-robin helper.
// Combinational definitions only; no latency or flow control of its own.
package cpu_pkg;
  localparam int CPU_DW    = 17;
  localparam int CPU_DEPTH = 8;
  localparam int CPU_AW    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; the winner is combinational and the
// last-granted pointer moves only when take is high. No backpressure.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  a_req,
  input  logic  b_req,
  input  logic  take,
  output port_t winner
);

  port_t last;

  // On a tie the side that did not win last time goes first.
  always_comb begin
    winner = PORT_A;
    if (a_req && b_req) begin
      winner = (last == PORT_A) ? PORT_B : PORT_A;
    end else if (b_req) begin
      winner = PORT_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= PORT_B;
    end else if (take) begin
      last <= winner;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto an external ram_1x17 bank: grant one cycle after the
// request is sampled, done the cycle after that, one transaction per three cycles; losers just wait.
module ram_arbiter
  import cpu_pkg::*;
#(
  parameter int DW    = CPU_DW,
  parameter int DEPTH = CPU_DEPTH,
  parameter int AW    = CPU_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req,
  input  logic             b_req,
  input  logic             a_we,
  input  logic             b_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [AW-1:0]    b_addr,
  input  logic [DW-1:0]    a_wdata,
  input  logic [DW-1:0]    b_wdata,
  output logic             a_gnt,
  output logic             b_gnt,
  output logic             a_done,
  output logic             b_done,
  output logic [DW-1:0]    a_rdata,
  output logic [DW-1:0]    b_rdata,
  output logic [DW-1:0]    ram_wd,
  output logic [DEPTH-1:0] ram_ws,
  output logic [DEPTH-1:0] ram_rs,
  input  logic [DW-1:0]    ram_rd
);

  state_t          state;
  state_t          state_nxt;
  port_t           owner;
  port_t           winner;
  logic            start;
  logic            lat_we;
  logic [AW-1:0]   lat_addr;
  logic [DEPTH-1:0] sel;

  assign start = (state == ST_IDLE) && (a_req || b_req);
  assign sel   = {{(DEPTH-1){1'b0}}, 1'b1} << lat_addr;

  rr_arb2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_req  (a_req),
    .b_req  (b_req),
    .take   (start),
    .winner (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Selects and strobes are decoded from state so an async reset clears them at once.
  always_comb begin
    state_nxt = state;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    a_done    = 1'b0;
    b_done    = 1'b0;
    ram_ws    = '0;
    ram_rs    = '0;
    case (state)
      ST_IDLE: begin
        if (a_req || b_req) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_nxt = ST_RESP;
        a_gnt     = (owner == PORT_A);
        b_gnt     = (owner == PORT_B);
        if (lat_we) ram_ws = sel;
        else        ram_rs = sel;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
        a_done    = (owner == PORT_A);
        b_done    = (owner == PORT_B);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ram_wd doubles as the latched write data and keeps its value across reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner    <= PORT_A;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      ram_wd   <= '0;
    end else if (start) begin
      owner <= winner;
      if (winner == PORT_A) begin
        lat_we   <= a_we;
        lat_addr <= a_addr;
        if (a_we) ram_wd <= a_wdata;
      end else begin
        lat_we   <= b_we;
        lat_addr <= b_addr;
        if (b_we) ram_wd <= b_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (state == ST_ACCESS && !lat_we) begin
      if (owner == PORT_A) a_rdata <= ram_rd;
      else                 b_rdata <= ram_rd;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: models the external bank and predicts every transaction
// from the arbitration rules (grant timing, round-robin, commit point).
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, b_req, a_we, b_we;
  logic [2:0]  a_addr, b_addr;
  logic [16:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_done, b_done;
  logic [16:0] a_rdata, b_rdata, ram_wd, ram_rd;
  logic [7:0]  ram_ws, ram_rs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_done(a_done), .b_done(b_done),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .ram_wd(ram_wd), .ram_ws(ram_ws), .ram_rs(ram_rs), .ram_rd(ram_rd)
  );

  // External bank: eight words, write on select at the clock edge, OR-combined read.
  logic [16:0] mem [8];
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (ram_ws[i]) mem[i] <= ram_wd;
  end
  always_comb begin
    ram_rd = '0;
    for (int i = 0; i < 8; i++) if (ram_rs[i]) ram_rd = ram_rd | mem[i];
  end

  // Reference model: a transaction accepted at edge e is granted in the cycle
  // after e, commits at edge e+1, and the next acceptance is possible at e+3.
  int          cyc = 0;
  int          next_free = 0;
  int          gcyc = -100;
  bit          last_b = 1'b1;
  bit          t_b = 1'b0;
  bit          t_we = 1'b0;
  int          t_addr = 0;
  logic [16:0] t_wdata = '0;
  logic [16:0] exp_mem [8];
  logic [16:0] exp_wd, exp_a_rd, exp_b_rd;
  logic        exp_a_gnt, exp_b_gnt, exp_a_done, exp_b_done;
  logic [7:0]  exp_ws, exp_rs;

  task automatic model_reset();
    gcyc      = -100;
    next_free = 0;
    last_b    = 1'b1;
    exp_wd    = '0;
    exp_a_rd  = '0;
    exp_b_rd  = '0;
    exp_a_gnt = 0; exp_b_gnt = 0; exp_a_done = 0; exp_b_done = 0;
    exp_ws    = '0; exp_rs = '0;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (gcyc == cyc - 1) begin
      if (t_we)     exp_mem[t_addr] = t_wdata;
      else if (t_b) exp_b_rd = exp_mem[t_addr];
      else          exp_a_rd = exp_mem[t_addr];
    end
    if (rst_n && cyc >= next_free && (a_req || b_req)) begin
      t_b     = !(a_req && (!b_req || last_b));
      last_b  = t_b;
      t_we    = t_b ? b_we : a_we;
      t_addr  = t_b ? int'(b_addr) : int'(a_addr);
      t_wdata = t_b ? b_wdata : a_wdata;
      gcyc      = cyc;
      next_free = cyc + 3;
      if (t_we) exp_wd = t_wdata;
    end
    exp_a_gnt  = (gcyc == cyc) && !t_b;
    exp_b_gnt  = (gcyc == cyc) && t_b;
    exp_a_done = (gcyc == cyc - 1) && !t_b;
    exp_b_done = (gcyc == cyc - 1) && t_b;
    exp_ws     = (gcyc == cyc && t_we)  ? (8'd1 << t_addr) : 8'd0;
    exp_rs     = (gcyc == cyc && !t_we) ? (8'd1 << t_addr) : 8'd0;
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #3;
    checks++;
    if ({a_gnt, b_gnt, a_done, b_done} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000", {a_gnt, b_gnt, a_done, b_done});
    end
    checks++;
    if (ram_ws !== 8'h00 || ram_rs !== 8'h00 || ram_wd !== 17'h0) begin
      errors++; $display("FAIL reset_ram_bus: got ws=%h rs=%h wd=%h expected 0", ram_ws, ram_rs, ram_wd);
    end
    checks++;
    if (a_rdata !== 17'h0 || b_rdata !== 17'h0) begin
      errors++; $display("FAIL reset_rdata: got a=%h b=%h expected 0", a_rdata, b_rdata);
    end
    #4;
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    a_req = 1; a_we = 1; a_addr = 3'd3; a_wdata = 17'd20;
    step();
    a_req = 0;
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      errors++; $display("FAIL write_gnt: got a=%b b=%b expected a=1 b=0", a_gnt, b_gnt);
    end
    checks++;
    if (ram_ws !== 8'b0000_1000 || ram_wd !== 17'd20) begin
      errors++; $display("FAIL write_bus: got ws=%b wd=%0d expected ws=00001000 wd=20", ram_ws, ram_wd);
    end
    step();
    checks++;
    if (a_done !== 1'b1 || a_gnt !== 1'b0 || ram_ws !== 8'h00) begin
      errors++; $display("FAIL write_done: got done=%b gnt=%b ws=%b expected 1 0 00000000", a_done, a_gnt, ram_ws);
    end
    step();
    checks++;
    if (a_done !== 1'b0 || ram_wd !== 17'd20) begin
      errors++; $display("FAIL write_after: got done=%b wd=%0d expected 0 20", a_done, ram_wd);
    end
  endtask

  task automatic test_read_back();
    b_req = 1; b_we = 0; b_addr = 3'd3;
    step();
    b_req = 0;
    checks++;
    if (b_gnt !== 1'b1 || ram_rs !== 8'b0000_1000 || ram_ws !== 8'h00) begin
      errors++; $display("FAIL read_access: got gnt=%b rs=%b ws=%b expected 1 00001000 00000000", b_gnt, ram_rs, ram_ws);
    end
    step();
    checks++;
    if (b_done !== 1'b1 || b_rdata !== 17'd20 || b_rdata !== exp_b_rd) begin
      errors++; $display("FAIL read_resp: got done=%b rdata=%0d expected 1 20", b_done, b_rdata);
    end
    step();
  endtask

  task automatic test_tie();
    int ga, gb;
    apply_reset();
    ga = -1; gb = -1;
    a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_addr = 3'd1; b_addr = 3'd2;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (a_gnt && b_gnt) begin
        errors++; $display("FAIL tie_overlap: got both grants at cycle %0d expected one", cyc);
      end
      checks++;
      if (a_gnt !== exp_a_gnt || b_gnt !== exp_b_gnt) begin
        errors++; $display("FAIL tie_model: got a=%b b=%b expected a=%b b=%b", a_gnt, b_gnt, exp_a_gnt, exp_b_gnt);
      end
      if (a_gnt && ga < 0) ga = i;
      if (b_gnt && gb < 0) gb = i;
    end
    idle_inputs();
    checks++;
    if (!(ga == 0 && gb >= ga + 3)) begin
      errors++; $display("FAIL tie_order: got A at %0d B at %0d expected A at 0 and B at least 3 later", ga, gb);
    end
    step(); step(); step();
  endtask

  task automatic test_fairness();
    port_seq_check: begin
      bit seq [$];
      apply_reset();
      a_req = 1; b_req = 1; a_we = 0; b_we = 0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (a_gnt) seq.push_back(1'b0);
        if (b_gnt) seq.push_back(1'b1);
      end
      idle_inputs();
      checks++;
      if (seq.size() != 4) begin
        errors++; $display("FAIL fair_count: got %0d grants expected 4", seq.size());
      end
      for (int i = 0; i < seq.size() && i < 4; i++) begin
        checks++;
        if (seq[i] !== bit'(i % 2)) begin
          errors++; $display("FAIL fair_order: grant %0d got %s expected %s", i, seq[i] ? "B" : "A", (i % 2) ? "B" : "A");
        end
      end
      step(); step(); step();
    end
  endtask

  task automatic test_input_change();
    a_req = 1; a_we = 1; a_addr = 3'd5; a_wdata = 17'd35;
    step();
    a_req = 0; a_wdata = 17'd7; a_addr = 3'd2;
    checks++;
    if (ram_wd !== 17'd35 || ram_ws !== 8'b0010_0000) begin
      errors++; $display("FAIL change_bus: got wd=%0d ws=%b expected 35 00100000", ram_wd, ram_ws);
    end
    step(); step();
    b_req = 1; b_we = 0; b_addr = 3'd5;
    step();
    b_req = 0;
    step();
    checks++;
    if (b_rdata !== 17'd35 || mem[2] !== exp_mem[2]) begin
      errors++; $display("FAIL change_word: got word5=%0d word2=%0d expected 35 %0d", b_rdata, mem[2], exp_mem[2]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [16:0] old6;
    old6 = mem[6];
    a_req = 1; a_we = 1; a_addr = 3'd6; a_wdata = old6 ^ 17'h1_5a5a;
    step();
    a_req = 0;
    checks++;
    if (ram_ws !== 8'b0100_0000) begin
      errors++; $display("FAIL midrst_pre: got ws=%b expected 01000000", ram_ws);
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ram_ws !== 8'h00 || a_gnt !== 1'b0) begin
      errors++; $display("FAIL midrst_abort: got ws=%b gnt=%b expected 0 0", ram_ws, a_gnt);
    end
    step();
    checks++;
    if (a_done !== 1'b0 || mem[6] !== old6) begin
      errors++; $display("FAIL midrst_commit: got done=%b word6=%h expected 0 %h", a_done, mem[6], old6);
    end
    #2;
    rst_n = 1'b1;
    a_req = 1; b_req = 1; a_we = 0; b_we = 0;
    step();
    idle_inputs();
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      errors++; $display("FAIL midrst_tie: got a=%b b=%b expected a=1 b=0", a_gnt, b_gnt);
    end
    step(); step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      a_req   = ($urandom_range(0, 2) != 0);
      b_req   = ($urandom_range(0, 2) != 0);
      a_we    = $urandom_range(0, 1) == 1;
      b_we    = $urandom_range(0, 1) == 1;
      a_addr  = 3'($urandom_range(0, 7));
      b_addr  = 3'($urandom_range(0, 7));
      a_wdata = 17'($urandom);
      b_wdata = 17'($urandom);
      step();
      checks++;
      if ({a_gnt, b_gnt, a_done, b_done} !== {exp_a_gnt, exp_b_gnt, exp_a_done, exp_b_done}) begin
        errors++; $display("FAIL rand_strobes cyc %0d: got %b expected %b", cyc,
          {a_gnt, b_gnt, a_done, b_done}, {exp_a_gnt, exp_b_gnt, exp_a_done, exp_b_done});
      end
      checks++;
      if (ram_ws !== exp_ws || ram_rs !== exp_rs || ram_wd !== exp_wd) begin
        errors++; $display("FAIL rand_bus cyc %0d: got ws=%b rs=%b wd=%h expected ws=%b rs=%b wd=%h",
          cyc, ram_ws, ram_rs, ram_wd, exp_ws, exp_rs, exp_wd);
      end
      checks++;
      if (a_rdata !== exp_a_rd || b_rdata !== exp_b_rd) begin
        errors++; $display("FAIL rand_rdata cyc %0d: got a=%h b=%h expected a=%h b=%h",
          cyc, a_rdata, b_rdata, exp_a_rd, exp_b_rd);
      end
    end
    idle_inputs();
    step(); step(); step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin
        errors++; $display("FAIL rand_bank word %0d: got %h expected %h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem[i]     = '0;
      exp_mem[i] = '0;
    end
    test_reset();
    test_single_write();
    test_read_back();
    test_tie();
    test_fairness();
    test_input_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DW, 17, data width of one RAM word (matches the ram_1x17 cell).
REQ-002 Parameter DEPTH, 8, number of ram_1x17 words in the bank.
REQ-003 Parameter AW, 3, address width, equal to log2(DEPTH).
REQ-004 Port clk input 1 — single clock; all state updates on the rising edge.
REQ-005 Port rst_n input 1 — asynchronous, active-low reset.
REQ-006 Ports a_req, b_req input 1 — requester A/B asks for one RAM transaction.
REQ-007 Ports a_we, b_we input 1 — 1 = write, 0 = read.
REQ-008 Ports a_addr, b_addr input AW — target word index.
REQ-009 Ports a_wdata, b_wdata input DW — write data.
REQ-010 Ports a_gnt, b_gnt output 1 — transaction accepted, high during the ACCESS cycle only.
REQ-011 Ports a_done, b_done output 1 — single-cycle completion pulse.
REQ-012 Ports a_rdata, b_rdata output DW — read result, held until that requester's next completed read.
REQ-013 Port ram_wd output DW — write data bus to all bank words.
REQ-014 Port ram_ws output DEPTH — one-hot per-word write select.
REQ-015 Port ram_rs output DEPTH — one-hot per-word read select.
REQ-016 Port ram_rd input DW — OR-combined read data returned from the bank.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS and RESP.
- IDLE -> ACCESS when any request is high.
- ACCESS -> RESP always.
- RESP -> IDLE always.
REQ-018 In IDLE, the winner SHALL be chosen round-robin.
- A single request wins outright.
- On simultaneous requests, the requester not granted last SHALL win.
REQ-019 On the IDLE->ACCESS edge, the winner's we, addr and wdata SHALL be latched; later input changes SHALL not affect the transaction.
REQ-020 In ACCESS, the winner's gnt SHALL be high, and only one gnt SHALL be high in any cycle.
REQ-021 Write transactions in ACCESS:
- ram_ws[addr] = 1, all other ws bits 0.
- ram_wd = latched wdata.
- The bank word SHALL update at the edge ending ACCESS.
REQ-022 Read transactions in ACCESS:
- ram_rs[addr] = 1.
- ram_rd SHALL be captured into the winner's rdata at the edge ending ACCESS.
REQ-023 Outside ACCESS, ram_ws and ram_rs SHALL be all zero; ram_wd SHALL hold its last value.
REQ-024 In RESP, the winner's done SHALL be high for exactly one cycle, with rdata already valid for reads.
REQ-025 Latency:
- Request seen in IDLE at edge N.
- gnt is high in cycle N+1.
- done is high in cycle N+2.
- The next grant is possible no earlier than cycle N+4 (3-cycle throughput).
REQ-026 A request held through RESP SHALL be arbitrated again in IDLE as a new transaction; requesters SHALL drop req in the cycle after done.
REQ-027 A request withdrawn before grant SHALL be ignored without side effects.
REQ-028 The last-granted pointer SHALL update only on entry to ACCESS.

Reset
REQ-029 While rst_n = 0, the following SHALL apply asynchronously:
- FSM = IDLE.
- All gnt/done = 0.
- ram_ws = ram_rs = 0, ram_wd = 0.
- a_rdata = b_rdata = 0.
- The last-granted pointer = B, so A wins the first tie.
REQ-030 Reset asserted during ACCESS SHALL abort the transaction: no write commits and no done pulse.

Structure
REQ-031 State encodings and the DW/DEPTH/AW defaults SHALL live in a shared CPU package (cpu_pkg).
REQ-032 One sub-module, rr_arb2 (two-way round-robin winner select plus pointer), SHALL be instantiated once.
REQ-033 The bank itself SHALL stay outside this block as DEPTH instances of ram_1x17.

Verification
REQ-034 Single write: A writes addr 3 with data 20 -> a_gnt in cycle 1 with ram_ws = 00001000 and ram_wd = 20; a_done in cycle 2.
REQ-035 Read-back: B reads addr 3 -> ram_rs = 00001000 in ACCESS; b_done with b_rdata = 20 in RESP.
REQ-036 Tie: A and B request together from reset -> A granted first, then B granted no earlier than 3 cycles later; the two grants never overlap.
REQ-037 Fairness: A and B both held high for 12 cycles -> grants alternate A, B, A, B.
REQ-038 Input change: A writes 35 to addr 5, and a_wdata changes to 7 during ACCESS -> word 5 receives 35.
REQ-039 Reset mid-operation: rst_n pulled low during a write's ACCESS cycle -> ram_ws = 0 immediately, no done pulse, and the next tie is granted to A.
